truth_table_sweeper: RTL and testbench
======================================

Name: truth_table_sweeper

Overview:
- Upstream stimulus stage for the small combinational logic blocks: drives every input pattern into a logic-under-test, waits for settling, samples its single output and assembles the observed truth table.
- Compares the observed table against an expected table and reports a mismatch count, so evolved or hand-written logic cells can be scored in hardware.
- Sits directly in front of the 4-input/1-output cell: pat_out feeds the cell inputs (MSB = first input) and the cell output returns on dut_in.

Parameters:
- N_IN, 4, number of logic-under-test inputs; table width is 2**N_IN.
- SETTLE_CYC, 1, cycles each pattern is held before the sample cycle; legal range 0..255.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  sweep request; sampled only in IDLE.
- expected  input  2**N_IN  expected table; bit k is the required output for pattern k; latched on start.
- dut_in  input  1  output of the logic-under-test.
- pat_out  output  N_IN  pattern driven to the logic-under-test.
- busy  output  1  high while sweeping.
- done  output  1  one-cycle pulse at sweep completion.
- table_out  output  2**N_IN  observed table; bit k = dut_in sampled for pattern k.
- mismatch_cnt  output  N_IN+1  number of bit positions where table_out differs from expected.
- match  output  1  high when mismatch_cnt == 0 at completion.

Behaviour:
- Interface: one clock; reset is asynchronous and active-low. Clock port is clk; reset port is rst_n.
- Reset values: state IDLE, pat_out 0, busy 0, done 0, table_out 0, mismatch_cnt 0, match 0, expected latch 0, settle counter 0.
- FSM states: IDLE, SETTLE, SAMPLE, FINISH.
- IDLE, start=1: latch expected, clear table_out and mismatch_cnt, set match 0, set pat_out 0 and settle counter SETTLE_CYC, busy 1.
  - Next state is SETTLE; if SETTLE_CYC == 0 the next state is SAMPLE instead.
- SETTLE: hold pat_out and decrement the counter. When the counter reaches 1, the next state is SAMPLE.
- SAMPLE: write dut_in into table_out[pat_out]; increment mismatch_cnt if dut_in != latched expected[pat_out].
  - If pat_out == 2**N_IN-1, go to FINISH.
  - Otherwise increment pat_out, reload the counter and return to SETTLE (or stay in SAMPLE when SETTLE_CYC == 0).
- FINISH (one cycle): done 1, busy 0, pat_out 0, and match registered as (final mismatch_cnt == 0). Next state is IDLE.
- Latency: done is high in the cycle after edge T0 + 2**N_IN*(SETTLE_CYC+1), where T0 is the edge that samples start.
- Each pattern occupies exactly SETTLE_CYC+1 cycles.
- table_out, mismatch_cnt and match hold their values after done until the next accepted start.
- start while not in IDLE (SETTLE, SAMPLE or FINISH) is ignored. The expected input is ignored outside the start edge.
- Arithmetic: the mismatch_cnt maximum is 2**N_IN, and its width N_IN+1 never wraps. pat_out increments without wrap; the terminal compare uses 2**N_IN-1.
- Reset mid-sweep: all registers return to reset values immediately (asynchronous). No done pulse is generated, and the partial table is discarded.
- dut_in is treated as a synchronous combinational return; no synchroniser.

Optional Feature:
- Macro: TTS_FIRST_FAIL_EN.
- Defined: adds outputs first_fail_idx (N_IN bits) and first_fail_vld (1 bit), both reset to 0 and cleared on an accepted start.
  - On the first SAMPLE with a mismatch, first_fail_idx is set to pat_out and first_fail_vld to 1. Later mismatches leave both unchanged.
  - Both hold after done.
- Undefined: these ports and registers do not exist; all other behaviour is identical.

Test Plan:
- Defaults; bench model for dut_in = 1 only for patterns 4'b1100 and 4'b1111; expected=16'h9000; pulse start -> done 32 edges after start, table_out=16'h9000, mismatch_cnt=0, match=1.
- Same model, expected=16'h1000 -> table_out=16'h9000, mismatch_cnt=1, match=0; with TTS_FIRST_FAIL_EN: first_fail_idx=15, first_fail_vld=1.
- dut_in tied 1, expected=16'h0000 -> table_out=16'hFFFF, mismatch_cnt=5'b10000, match=0.
- SETTLE_CYC=3, model as in the first scenario -> done 64 edges after start; each pat_out value is held exactly 4 cycles; results as in the first scenario.
- Pulse start again at pattern 6 while busy -> ignored; sweep completes at the original time with an unchanged result.
- Assert rst_n=0 at pattern 9, release it, then start -> outputs are zero immediately on reset with no done pulse; the new sweep completes with the correct table.

Source files
------------

// File: rtl/truth_table_sweeper.sv
// truth_table_sweeper: walks every input pattern of a small logic-under-test,
// waits SETTLE_CYC cycles per pattern, samples the single returned output into
// an observed truth table and counts disagreements with a latched expected table.
// Optional build macro TTS_FIRST_FAIL_EN adds first_fail_idx / first_fail_vld,
// which record the lowest pattern whose sample disagreed.
module truth_table_sweeper #(
    parameter int N_IN       = 4,
    parameter int SETTLE_CYC = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [2**N_IN-1:0]   expected,
    input  logic                 dut_in,
    output logic [N_IN-1:0]      pat_out,
    output logic                 busy,
    output logic                 done,
    output logic [2**N_IN-1:0]   table_out,
    output logic [N_IN:0]        mismatch_cnt,
    output logic                 match
`ifdef TTS_FIRST_FAIL_EN
    ,
    output logic [N_IN-1:0]      first_fail_idx,
    output logic                 first_fail_vld
`endif
);

    localparam int              W        = 2**N_IN;
    localparam logic [N_IN-1:0] PAT_LAST = N_IN'(W-1);
    localparam logic [7:0]      CNT_LOAD = 8'(SETTLE_CYC);

    typedef enum logic [1:0] {IDLE, SETTLE, SAMPLE, FINISH} state_t;

    state_t          state_q, state_d;
    logic [7:0]      cnt_q, cnt_d;
    logic [N_IN-1:0] pat_q, pat_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic [W-1:0]    tbl_q, tbl_d;
    logic [W-1:0]    exp_q, exp_d;
    logic [N_IN:0]   mis_q, mis_d;
    logic            match_q, match_d;
    logic            miss;
`ifdef TTS_FIRST_FAIL_EN
    logic [N_IN-1:0] ff_idx_q, ff_idx_d;
    logic            ff_vld_q, ff_vld_d;
`endif

    // Next-state and datapath updates; every register holds unless its state acts on it.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        pat_d   = pat_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        tbl_d   = tbl_q;
        exp_d   = exp_q;
        mis_d   = mis_q;
        match_d = match_q;
`ifdef TTS_FIRST_FAIL_EN
        ff_idx_d = ff_idx_q;
        ff_vld_d = ff_vld_q;
`endif
        miss = dut_in ^ exp_q[pat_q];
        case (state_q)
            IDLE: begin
                if (start) begin
                    exp_d   = expected;
                    tbl_d   = '0;
                    mis_d   = '0;
                    match_d = 1'b0;
                    pat_d   = '0;
                    cnt_d   = CNT_LOAD;
                    busy_d  = 1'b1;
`ifdef TTS_FIRST_FAIL_EN
                    ff_idx_d = '0;
                    ff_vld_d = 1'b0;
`endif
                    state_d = (SETTLE_CYC == 0) ? SAMPLE : SETTLE;
                end
            end
            SETTLE: begin
                cnt_d = cnt_q - 8'd1;
                if (cnt_q == 8'd1) state_d = SAMPLE;
            end
            SAMPLE: begin
                tbl_d[pat_q] = dut_in;
                if (miss) mis_d = mis_q + (N_IN+1)'(1);
`ifdef TTS_FIRST_FAIL_EN
                if (miss && !ff_vld_q) begin
                    ff_idx_d = pat_q;
                    ff_vld_d = 1'b1;
                end
`endif
                if (pat_q == PAT_LAST) begin
                    // match uses the count including this last sample
                    state_d = FINISH;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    pat_d   = '0;
                    match_d = (mis_d == '0);
                end else begin
                    pat_d   = pat_q + N_IN'(1);
                    cnt_d   = CNT_LOAD;
                    state_d = (SETTLE_CYC == 0) ? SAMPLE : SETTLE;
                end
            end
            FINISH:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State register; asynchronous reset discards any partial sweep without a done pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            pat_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            tbl_q   <= '0;
            exp_q   <= '0;
            mis_q   <= '0;
            match_q <= 1'b0;
`ifdef TTS_FIRST_FAIL_EN
            ff_idx_q <= '0;
            ff_vld_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pat_q   <= pat_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            tbl_q   <= tbl_d;
            exp_q   <= exp_d;
            mis_q   <= mis_d;
            match_q <= match_d;
`ifdef TTS_FIRST_FAIL_EN
            ff_idx_q <= ff_idx_d;
            ff_vld_q <= ff_vld_d;
`endif
        end
    end

    assign pat_out      = pat_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign table_out    = tbl_q;
    assign mismatch_cnt = mis_q;
    assign match        = match_q;
`ifdef TTS_FIRST_FAIL_EN
    assign first_fail_idx = ff_idx_q;
    assign first_fail_vld = ff_vld_q;
`endif

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Bench for truth_table_sweeper: three instances (SETTLE_CYC = 1, 3, 0) share
// start/expected; each drives its own copy of the logic-under-test model.
module tb_truth_table_sweeper;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [15:0] expected = '0;

    logic [3:0]  pat_v   [3];
    logic        busy_v  [3];
    logic        done_v  [3];
    logic        match_v [3];
    logic        din_v   [3];
    logic [15:0] tbl_v   [3];
    logic [4:0]  mis_v   [3];
`ifdef TTS_FIRST_FAIL_EN
    logic [3:0]  ffi_v   [3];
    logic        ffv_v   [3];
`endif

    int          mode = 0;      // 0: ones at 12 and 15, 1: tied high, 2: random table
    logic [15:0] rnd_tt = '0;
    int          total = 0;
    int          bad = 0;
    int          cyc = 0;
    int          settle [3] = '{1, 3, 0};

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Logic-under-test model feeding each instance
    always_comb begin
        for (int i = 0; i < 3; i++) begin
            case (mode)
                0:       din_v[i] = (pat_v[i] == 4'd12) || (pat_v[i] == 4'd15);
                1:       din_v[i] = 1'b1;
                default: din_v[i] = rnd_tt[pat_v[i]];
            endcase
        end
    end

    truth_table_sweeper u_s1 (
        .clk(clk), .rst_n(rst_n), .start(start), .expected(expected), .dut_in(din_v[0]),
        .pat_out(pat_v[0]), .busy(busy_v[0]), .done(done_v[0]), .table_out(tbl_v[0]),
        .mismatch_cnt(mis_v[0]), .match(match_v[0])
`ifdef TTS_FIRST_FAIL_EN
        , .first_fail_idx(ffi_v[0]), .first_fail_vld(ffv_v[0])
`endif
    );

    truth_table_sweeper #(.N_IN(4), .SETTLE_CYC(3)) u_s3 (
        .clk(clk), .rst_n(rst_n), .start(start), .expected(expected), .dut_in(din_v[1]),
        .pat_out(pat_v[1]), .busy(busy_v[1]), .done(done_v[1]), .table_out(tbl_v[1]),
        .mismatch_cnt(mis_v[1]), .match(match_v[1])
`ifdef TTS_FIRST_FAIL_EN
        , .first_fail_idx(ffi_v[1]), .first_fail_vld(ffv_v[1])
`endif
    );

    truth_table_sweeper #(.N_IN(4), .SETTLE_CYC(0)) u_s0 (
        .clk(clk), .rst_n(rst_n), .start(start), .expected(expected), .dut_in(din_v[2]),
        .pat_out(pat_v[2]), .busy(busy_v[2]), .done(done_v[2]), .table_out(tbl_v[2]),
        .mismatch_cnt(mis_v[2]), .match(match_v[2])
`ifdef TTS_FIRST_FAIL_EN
        , .first_fail_idx(ffi_v[2]), .first_fail_vld(ffv_v[2])
`endif
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Reference truth table straight from the model's rules
    function automatic logic [15:0] ref_tt();
        logic [15:0] t;
        for (int k = 0; k < 16; k++)
            t[k] = (mode == 0) ? (k == 12 || k == 15) : (mode == 1) ? 1'b1 : rnd_tt[k];
        return t;
    endfunction

    task automatic chk_idle_zero(input string tag);
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("%s_pat%0d", tag, i), 32'(pat_v[i]), 0);
            chk($sformatf("%s_busy%0d", tag, i), 32'(busy_v[i]), 0);
            chk($sformatf("%s_done%0d", tag, i), 32'(done_v[i]), 0);
            chk($sformatf("%s_tbl%0d", tag, i), 32'(tbl_v[i]), 0);
            chk($sformatf("%s_mis%0d", tag, i), 32'(mis_v[i]), 0);
            chk($sformatf("%s_match%0d", tag, i), 32'(match_v[i]), 0);
`ifdef TTS_FIRST_FAIL_EN
            chk($sformatf("%s_ffi%0d", tag, i), 32'(ffi_v[i]), 0);
            chk($sformatf("%s_ffv%0d", tag, i), 32'(ffv_v[i]), 0);
`endif
        end
    endtask

    task automatic chk_result(input string tag, input int i, input logic [15:0] tt,
                              input int mm, input int ff, input bit ffv);
        chk($sformatf("%s_tbl%0d", tag, i), 32'(tbl_v[i]), 32'(tt));
        chk($sformatf("%s_mis%0d", tag, i), 32'(mis_v[i]), 32'(mm));
        chk($sformatf("%s_match%0d", tag, i), 32'(match_v[i]), 32'(mm == 0));
`ifdef TTS_FIRST_FAIL_EN
        chk($sformatf("%s_ffi%0d", tag, i), 32'(ffi_v[i]), 32'(ff));
        chk($sformatf("%s_ffv%0d", tag, i), 32'(ffv_v[i]), 32'(ffv));
`else
        if (ff < 0 && ffv) $display("note: unreachable");
`endif
    endtask

    // One sweep on all instances, checked every cycle; glitch re-pulses start mid-sweep
    task automatic sweep(input logic [15:0] ev, input bit glitch);
        logic [15:0] tt;
        int mm, ff, t0, len;
        bit ffv;
        tt = ref_tt();
        mm = 0; ff = 0; ffv = 0;
        for (int k = 0; k < 16; k++) begin
            if (tt[k] != ev[k]) begin
                mm++;
                if (!ffv) begin ffv = 1; ff = k; end
            end
        end
        @(negedge clk);
        start = 1'b1;
        expected = ev;
        @(posedge clk);
        #1 t0 = cyc;
        for (int n = 0; n < 70; n++) begin
            @(negedge clk);
            chk("cycle", 32'(cyc - t0), 32'(n));
            start = glitch && (n == 12);
            expected = (glitch && n == 12) ? ~ev : 16'($urandom);
            for (int i = 0; i < 3; i++) begin
                len = 16 * (settle[i] + 1);
                if (n == 0) begin
                    chk($sformatf("clr_tbl%0d", i), 32'(tbl_v[i]), 0);
                    chk($sformatf("clr_mis%0d", i), 32'(mis_v[i]), 0);
                    chk($sformatf("clr_match%0d", i), 32'(match_v[i]), 0);
                end
                if (n < len) begin
                    chk($sformatf("busy%0d", i), 32'(busy_v[i]), 1);
                    chk($sformatf("done%0d", i), 32'(done_v[i]), 0);
                    chk($sformatf("pat%0d_n%0d", i, n), 32'(pat_v[i]), 32'(n / (settle[i] + 1)));
                end else begin
                    chk($sformatf("done%0d_n%0d", i, n), 32'(done_v[i]), 32'(n == len));
                    chk($sformatf("busy%0d", i), 32'(busy_v[i]), 0);
                    chk($sformatf("pat%0d", i), 32'(pat_v[i]), 0);
                    if (n == len || n == 69) chk_result($sformatf("res_n%0d", n), i, tt, mm, ff, ffv);
                end
            end
        end
        start = 1'b0;
    endtask

    // Start a sweep, hit reset at pattern 9 of the SETTLE_CYC=1 instance
    task automatic reset_mid();
        bit hit;
        hit = 0;
        @(negedge clk);
        start = 1'b1;
        expected = 16'h9000;
        @(negedge clk);
        start = 1'b0;
        for (int n = 0; n < 40 && !hit; n++) begin
            if (pat_v[0] == 4'd9) hit = 1;
            else @(negedge clk);
        end
        chk("reach_pat9", 32'(hit), 1);
        rst_n = 1'b0;
        #1 chk_idle_zero("rst_async");
        @(posedge clk);
        #1 chk_idle_zero("rst_hold");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk_idle_zero("rst_rel");
    endtask

    initial begin
        logic [15:0] ev;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        chk_idle_zero("reset");
        rst_n = 1'b1;
        @(negedge clk);

        mode = 0; sweep(16'h9000, 0);
        mode = 0; sweep(16'h1000, 0);
        mode = 1; sweep(16'h0000, 0);
        mode = 0; sweep(16'h9000, 1);
        mode = 0; reset_mid();
        mode = 0; sweep(16'h9000, 0);
        for (int r = 0; r < 6; r++) begin
            mode = 2;
            rnd_tt = 16'($urandom);
            ev = (r % 2 == 0) ? rnd_tt : rnd_tt ^ 16'($urandom);
            sweep(ev, bit'($urandom_range(0, 1)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
